// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier sequencers: FSM state encoding
// and the {ld,shr} control codes understood by the add/shift register.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    // {ld, shr} codes driven into the add/shift register
    localparam logic [1:0] CTL_HOLD     = 2'b00;
    localparam logic [1:0] CTL_LOAD     = 2'b10;
    localparam logic [1:0] CTL_SHIFT    = 2'b01;
    localparam logic [1:0] CTL_ADDSHIFT = 2'b11;

endpackage

// File: rtl/mult_seq_ctrl_iter_counter.sv
// Iteration counter for sequenced datapaths: sync clear, enable, and a
// terminal-count flag on the last iteration (N/2-1). Saturates at N/2.
module iter_counter #(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N/2+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N/2-1);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(N/2);

    // Saturating at N/2 keeps iter from wrapping if enable is ever held too long
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the shift-and-add multiplier: one load, then N/2 shift or
// add-and-shift steps chosen by the register LSB. Optional macro: EARLY_EXIT_EN.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter  int N     = 4,
    localparam int CNT_W = $clog2(N/2+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lsb,
    input  logic             zero_rem,
    output logic             ld,
    output logic             shr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    state_t     state;
    state_t     state_next;
    logic [1:0] ctl;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_tc;
    logic       add_bit;

`ifdef EARLY_EXIT_EN
    // Once the remaining multiplier bits are all zero, adds cannot change the product
    assign add_bit = lsb & ~zero_rem;
`else
    logic unused_zero_rem;
    assign unused_zero_rem = zero_rem;
    assign add_bit         = lsb;
`endif

    iter_counter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (iter),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ctl        = CTL_HOLD;
        busy       = 1'b0;
        done       = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    cnt_clr    = 1'b1;
                end
            end
            LOAD: begin
                ctl        = CTL_LOAD;
                busy       = 1'b1;
                state_next = STEP;
            end
            // ld is the only Mealy output: it follows the live register LSB
            STEP: begin
                ctl    = add_bit ? CTL_ADDSHIFT : CTL_SHIFT;
                busy   = 1'b1;
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign {ld, shr} = ctl;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: three instances (N=4, N=16, N=8),
// expected outputs pushed per driven cycle and popped at the negedge.
module tb_mult_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_a   [3];
    logic       start_a [3];
    logic       lsb_a   [3];
    logic       zr_a    [3];
    logic       ld_a    [3];
    logic       shr_a   [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic [1:0] iter0;
    logic [3:0] iter1;
    logic [2:0] iter2;

    int errors = 0;
    int checks = 0;

    // Reference model state per instance: 0 IDLE, 1 LOAD, 2 STEP, 3 DONE
    int mst   [3];
    int miter [3];
    int nhalf [3] = '{2, 8, 4};

    logic [7:0] sb[$];

`ifdef EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    mult_seq_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst(rst_a[0]), .start(start_a[0]), .lsb(lsb_a[0]), .zero_rem(zr_a[0]),
        .ld(ld_a[0]), .shr(shr_a[0]), .busy(busy_a[0]), .done(done_a[0]), .iter(iter0)
    );

    mult_seq_ctrl #(.N(16)) dut16 (
        .clk(clk), .rst(rst_a[1]), .start(start_a[1]), .lsb(lsb_a[1]), .zero_rem(zr_a[1]),
        .ld(ld_a[1]), .shr(shr_a[1]), .busy(busy_a[1]), .done(done_a[1]), .iter(iter1)
    );

    mult_seq_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst(rst_a[2]), .start(start_a[2]), .lsb(lsb_a[2]), .zero_rem(zr_a[2]),
        .ld(ld_a[2]), .shr(shr_a[2]), .busy(busy_a[2]), .done(done_a[2]), .iter(iter2)
    );

    // Observed outputs packed as {ld, shr, busy, done, iter[3:0]}
    function automatic logic [7:0] get_obs(input int id);
        logic [3:0] it;
        case (id)
            0:       it = {2'b00, iter0};
            1:       it = iter1;
            default: it = {1'b0, iter2};
        endcase
        return {ld_a[id], shr_a[id], busy_a[id], done_a[id], it};
    endfunction

    function automatic logic [7:0] model_out(input int id);
        logic l;
        logic s;
        logic b;
        logic d;
        l = 1'b0;
        s = 1'b0;
        b = 1'b0;
        d = 1'b0;
        case (mst[id])
            1: begin l = 1'b1; b = 1'b1; end
            2: begin s = 1'b1; b = 1'b1; l = lsb_a[id] & ~(EARLY & zr_a[id]); end
            3: d = 1'b1;
            default: ;
        endcase
        return {l, s, b, d, 4'(miter[id])};
    endfunction

    function automatic void model_advance(input int id);
        if (rst_a[id]) begin
            mst[id]   = 0;
            miter[id] = 0;
        end else begin
            case (mst[id])
                0: if (start_a[id]) begin mst[id] = 1; miter[id] = 0; end
                1: mst[id] = 2;
                2: begin
                    miter[id] = miter[id] + 1;
                    if (miter[id] == nhalf[id]) mst[id] = 3;
                end
                default: mst[id] = 0;
            endcase
        end
    endfunction

    task automatic drive(input int id, input logic r, input logic s, input logic l, input logic z);
        rst_a[id]   = r;
        start_a[id] = s;
        lsb_a[id]   = l;
        zr_a[id]    = z;
        sb.push_back(model_out(id));
    endtask

    task automatic step_cycle(input int id);
        @(posedge clk);
        model_advance(id);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        logic [7:0] o;
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1; start_a[i] = 1'b0; lsb_a[i] = 1'b0; zr_a[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) model_advance(i);
        #1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = sb.pop_front();
                o = get_obs(i);
                checks++;
                if (o !== e || o !== 8'h00) begin
                    errors++;
                    $display("[TB] FAIL reset inst %0d cyc %0d: got %b want %b", i, c, o, e);
                end
            end
            @(posedge clk);
            for (int i = 0; i < 3; i++) model_advance(i);
            #1;
        end
    endtask

    task automatic test_basic_n4();
        logic [7:0] e;
        logic [7:0] o;
        logic       lseq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] ctl  [6];
        logic [3:0] it_done = 4'hf;
        int         done_cyc = -1;
        for (int c = 0; c < 6; c++) begin
            drive(0, 1'b0, c == 0, lseq[c], 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL basic_n4 cyc %0d: got %b want %b", c, o, e);
            end
            ctl[c] = o[7:6];
            if (o[4] === 1'b1) begin done_cyc = c; it_done = o[3:0]; end
            step_cycle(0);
        end
        checks++;
        if (ctl[1] !== 2'b10 || ctl[2] !== 2'b11 || ctl[3] !== 2'b01) begin
            errors++;
            $display("[TB] FAIL basic_n4 ctl seq: got %b %b %b want 10 11 01", ctl[1], ctl[2], ctl[3]);
        end
        checks++;
        if (done_cyc !== 4 || it_done !== 4'd2) begin
            errors++;
            $display("[TB] FAIL basic_n4 done: got cyc %0d iter %0d want cyc 4 iter 2", done_cyc, it_done);
        end
    endtask

    task automatic test_all_ones_n16();
        logic [7:0] e;
        logic [7:0] o;
        int n_add = 0;
        int n_busy = 0;
        int n_done = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1, 1'b0, c == 0, 1'b1, 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(1);
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL ones_n16 cyc %0d: got %b want %b", c, o, e);
            end
            if (o[7:6] === 2'b11) n_add++;
            if (o[5] === 1'b1) n_busy++;
            if (o[4] === 1'b1) n_done++;
            step_cycle(1);
        end
        checks++;
        if (n_add != 8 || n_busy != 9 || n_done != 1 || iter1 !== 4'd8) begin
            errors++;
            $display("[TB] FAIL ones_n16 counts: got add %0d busy %0d done %0d iter %0d want 8 9 1 8",
                     n_add, n_busy, n_done, iter1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic [7:0] o;
        int n_load = 0;
        int n_done = 0;
        int bad_pos = 0;
        for (int c = 0; c < 26; c++) begin
            drive(0, 1'b0, c < 20, 1'($urandom_range(0, 1)), 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc %0d: got %b want %b", c, o, e);
            end
            if (o[7:6] === 2'b10) n_load++;
            if (o[4] === 1'b1) begin
                n_done++;
                if (c % 5 != 4) bad_pos++;
            end
            step_cycle(0);
        end
        checks++;
        if (n_load != 4 || n_done != 4 || bad_pos != 0) begin
            errors++;
            $display("[TB] FAIL back_to_back counts: got load %0d done %0d misplaced %0d want 4 4 0",
                     n_load, n_done, bad_pos);
        end
    endtask

    task automatic test_abort();
        logic [7:0] e;
        logic [7:0] o;
        logic [7:0] after_rst = 8'hff;
        int n_done = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1, c == 3, c == 0, 1'b1, 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(1);
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL abort cyc %0d: got %b want %b", c, o, e);
            end
            if (c == 4) after_rst = o;
            if (o[4] === 1'b1) n_done++;
            step_cycle(1);
        end
        checks++;
        if (after_rst !== 8'h00 || n_done != 0) begin
            errors++;
            $display("[TB] FAIL abort idle: got %b done %0d want 00000000 done 0", after_rst, n_done);
        end
        for (int c = 0; c < 12; c++) begin
            drive(1, 1'b0, c == 0, 1'($urandom_range(0, 1)), 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(1);
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL abort_rerun cyc %0d: got %b want %b", c, o, e);
            end
            if (o[4] === 1'b1) n_done++;
            step_cycle(1);
        end
        checks++;
        if (n_done != 1 || iter1 !== 4'd8) begin
            errors++;
            $display("[TB] FAIL abort_rerun result: got done %0d iter %0d want 1 8", n_done, iter1);
        end
    endtask

    task automatic test_early_exit();
        logic [7:0] e;
        logic [7:0] o;
        int n_ld_step = 0;
        int done_cyc = -1;
        int want_ld = EARLY ? 1 : 4;
        for (int c = 0; c < 8; c++) begin
            drive(2, 1'b0, c == 0, 1'b1, c >= 3);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(2);
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL early_exit cyc %0d: got %b want %b", c, o, e);
            end
            if (o[7:6] === 2'b11) n_ld_step++;
            if (o[4] === 1'b1) done_cyc = c;
            step_cycle(2);
        end
        checks++;
        if (n_ld_step != want_ld || done_cyc != 6) begin
            errors++;
            $display("[TB] FAIL early_exit summary: got adds %0d done cyc %0d want %0d 6",
                     n_ld_step, done_cyc, want_ld);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mst[i] = 0; miter[i] = 0;
            rst_a[i] = 1'b1; start_a[i] = 1'b0; lsb_a[i] = 1'b0; zr_a[i] = 1'b0;
        end
        $display("[TB] starting mult_seq_ctrl bench");
        test_reset();
        test_basic_n4();
        test_all_ones_n16();
        test_back_to_back();
        test_abort();
        test_early_exit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
